clk_div_monitor: RTL

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//   Measures the period of an asynchronous divided clock (div_in) in clk
//   cycles, compares each measurement with exp_period (+/- TOL) and locks
//   after LOCK_COUNT consecutive matches. Once locked, a mismatch or a
//   timeout (no edge for 2^CNT_W-1 cycles) latches a sticky fault that only
//   enable low clears.
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   enable       : run the monitor; low returns to IDLE
//   div_in       : divided clock under test (asynchronous)
//   exp_period   : expected div_in period in clk cycles
//   period       : last measured period (registered)
//   period_valid : one-cycle pulse when period updates
//   locked       : high in LOCKED
//   err          : high in FAULT
module clk_div_monitor #(
   parameter int CNT_W      = 8,
   parameter int LOCK_COUNT = 4,
   parameter int TOL        = 0
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             div_in,
   input  logic [CNT_W-1:0] exp_period,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_MEASURE, S_LOCKED, S_FAULT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] EXP_MIN = CNT_W'(2);
   localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);
   localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

   state_t           r_state, w_state_nxt;
   logic             r_sync1, r_sync2, r_hist;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_exp;
   logic [CNT_W-1:0] r_period;
   logic             r_pv, w_pv_nxt;
   logic [3:0]       r_mcnt, w_mcnt_nxt;

   logic             w_rise, w_timeout, w_match;
   logic [CNT_W:0]   w_absdiff;

   assign w_rise    = r_sync2 & ~r_hist;
   assign w_timeout = (r_cnt == CNT_MAX);

   // Absolute difference ordered so the subtraction can never wrap.
   assign w_absdiff = (r_cnt >= r_exp) ? {1'b0, r_cnt - r_exp}
                                       : {1'b0, r_exp - r_cnt};
   // r_exp was captured at the previous rise, so an exp_period change
   // applies to the measurement that starts at the rise where it is seen.
   assign w_match   = (r_exp >= EXP_MIN) && (w_absdiff <= TOL_V);

   always_comb begin
      w_state_nxt = r_state;
      w_mcnt_nxt  = r_mcnt;
      w_pv_nxt    = 1'b0;
      if (!enable) begin
         // enable low beats any simultaneous rise or timeout
         w_state_nxt = S_IDLE;
         w_mcnt_nxt  = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_ARM;
               w_mcnt_nxt  = '0;
            end
            S_ARM: begin
               // first rise only opens the first interval
               if (w_rise) w_state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
               if (w_timeout) begin
                  w_state_nxt = S_ARM;
                  w_mcnt_nxt  = '0;
               end else if (w_rise) begin
                  w_pv_nxt = 1'b1;
                  if (w_match) begin
                     w_mcnt_nxt = r_mcnt + 4'd1;
                     if (r_mcnt == LOCK_N - 4'd1) w_state_nxt = S_LOCKED;
                  end else begin
                     w_mcnt_nxt = '0;
                  end
               end
            end
            S_LOCKED: begin
               if (w_timeout) begin
                  w_state_nxt = S_FAULT;
               end else if (w_rise) begin
                  w_pv_nxt = 1'b1;
                  if (!w_match) w_state_nxt = S_FAULT;
               end
            end
            S_FAULT: begin
               if (w_rise && !w_timeout) w_pv_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_mcnt_nxt  = '0;
            end
         endcase
      end
   end

   // Run counter: cleared while idle, restarts at 1 on each rise and
   // saturates so a stuck input parks on the timeout value.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_state_nxt == S_IDLE)  w_cnt_nxt = '0;
      else if (w_rise)            w_cnt_nxt = CNT_W'(1);
      else if (r_cnt != CNT_MAX)  w_cnt_nxt = r_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_hist   <= 1'b0;
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_exp    <= '0;
         r_period <= '0;
         r_pv     <= 1'b0;
         r_mcnt   <= '0;
      end else begin
         r_sync1  <= div_in;
         r_sync2  <= r_sync1;
         r_hist   <= r_sync2;
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_mcnt   <= w_mcnt_nxt;
         r_pv     <= w_pv_nxt;
         if (w_pv_nxt)         r_period <= r_cnt;
         if (w_rise && enable) r_exp    <= exp_period;
      end
   end

   assign period       = r_period;
   assign period_valid = r_pv;
   assign locked       = (r_state == S_LOCKED);
   assign err          = (r_state == S_FAULT);

endmodule
